// File: rtl/updi_pkg.sv
// Shared states, error codes and UPDI byte constants for the instruction sequencer.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package updi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SYNCH,
    ST_WR_OPCODE,
    ST_WR_DATA,
    ST_WAIT_ACK,
    ST_RD_RESP
  } updi_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BAD_ACK = 2'd2,
    ERR_ABORTED = 2'd3
  } updi_err_t;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;
  localparam logic [7:0] UPDI_ACK   = 8'h40;

endpackage

// File: rtl/updi_timeout_counter.sv
// Counts idle cycles while an RX byte is awaited; flags expiry at TIMEOUT_CYCLES-1.
// Latency: expired is combinational from the count register.
// Backpressure: none; clr wins over inc, and the count saturates at the expiry value.
module updi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  // Idle-cycle count: restart on clr, otherwise advance until the expiry value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/updi_instruction_sequencer.sv
// Runs one UPDI instruction: SYNCH/opcode/data out to the TX FIFO, ACKs and response bytes in from RX.
// Latency: one TX byte per cycle as a registered write; RX bytes consumed in the cycle they are seen.
// Backpressure: holds state while tx_fifo_full; waits on rx_fifo_empty up to TIMEOUT_CYCLES per byte.
module updi_instruction_sequencer
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int MAX_RX_SIZE    = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int DW = $clog2(MAX_DATA_SIZE) + 1,
  localparam int RW = $clog2(MAX_RX_SIZE) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          ready,
  output logic                          done,
  output logic                          error,
  output updi_err_t                     error_code,
  output logic                          waiting_for_ack,
  input  logic                          send_synch,
  input  logic [7:0]                    opcode,
  input  logic [MAX_DATA_SIZE-1:0][7:0] data,
  input  logic [DW-1:0]                 data_len,
  input  logic [MAX_DATA_SIZE-1:0]      wait_ack_after,
  input  logic [RW-1:0]                 rx_len,
  output logic [7:0]                    tx_fifo_data,
  output logic                          tx_fifo_wr_en,
  input  logic                          tx_fifo_full,
  input  logic [7:0]                    rx_fifo_data,
  output logic                          rx_fifo_rd_en,
  input  logic                          rx_fifo_empty,
  output logic [MAX_RX_SIZE-1:0][7:0]   rx_data,
  output logic [RW-1:0]                 rx_count
);

  localparam int DI = DW - 1;
  localparam int RI = RW - 1;
  localparam logic [DW-1:0] DATA_MAX = DW'(MAX_DATA_SIZE);
  localparam logic [RW-1:0] RX_MAX   = RW'(MAX_RX_SIZE);

  updi_seq_state_t state, state_nxt, after_data;
  updi_err_t       end_code;

  logic                          init_done;
  logic                          send_synch_l;
  logic [7:0]                    opcode_l;
  logic [MAX_DATA_SIZE-1:0][7:0] data_l;
  logic [DW-1:0]                 data_len_l;
  logic [MAX_DATA_SIZE-1:0]      wait_ack_l;
  logic [RW-1:0]                 rx_len_l;

  logic [DW-1:0] data_idx, idx_nxt, idx_inc;
  logic          last_byte, latch, tx_push, capture, in_rx, expired;
  logic [7:0]    tx_byte;

  // ready stays low through reset and the first edge after release
  assign ready           = init_done && (state == ST_IDLE);
  assign in_rx           = (state == ST_WAIT_ACK) || (state == ST_RD_RESP);
  assign rx_fifo_rd_en   = in_rx && !rx_fifo_empty;
  assign waiting_for_ack = (state == ST_WAIT_ACK);
  assign error           = (error_code != ERR_NONE);
  assign idx_inc         = data_idx + DW'(1);
  assign last_byte       = (idx_inc == data_len_l);

  updi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_rx || rx_fifo_rd_en),
    .inc     (in_rx && !rx_fifo_rd_en),
    .expired (expired)
  );

  // Next state, TX byte selection, RX consumption and instruction ending
  always_comb begin
    state_nxt  = state;
    idx_nxt    = data_idx;
    tx_push    = 1'b0;
    tx_byte    = 8'h00;
    capture    = 1'b0;
    latch      = 1'b0;
    done       = 1'b0;
    end_code   = ERR_NONE;
    after_data = (rx_len_l != '0) ? ST_RD_RESP : ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (start && ready) begin
          latch     = 1'b1;
          state_nxt = send_synch ? ST_WR_SYNCH : ST_WR_OPCODE;
        end
      end
      ST_WR_SYNCH: begin
        if (!tx_fifo_full) begin
          tx_push   = 1'b1;
          tx_byte   = UPDI_SYNCH;
          state_nxt = ST_WR_OPCODE;
        end
      end
      ST_WR_OPCODE: begin
        if (!tx_fifo_full) begin
          tx_push   = 1'b1;
          tx_byte   = opcode_l;
          state_nxt = (data_len_l != '0) ? ST_WR_DATA : after_data;
        end
      end
      ST_WR_DATA: begin
        if (!tx_fifo_full) begin
          tx_push = 1'b1;
          tx_byte = data_l[data_idx[DI-1:0]];
          if (wait_ack_l[data_idx[DI-1:0]]) state_nxt = ST_WAIT_ACK;
          else if (last_byte)               state_nxt = after_data;
          else                              idx_nxt   = idx_inc;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_fifo_rd_en) begin
          if (rx_fifo_data != UPDI_ACK) begin
            state_nxt = ST_IDLE;
            end_code  = ERR_BAD_ACK;
          end else if (last_byte) begin
            state_nxt = after_data;
          end else begin
            idx_nxt   = idx_inc;
            state_nxt = ST_WR_DATA;
          end
        end else if (expired) begin
          state_nxt = ST_IDLE;
          end_code  = ERR_TIMEOUT;
        end
      end
      ST_RD_RESP: begin
        if (rx_fifo_rd_en) begin
          capture = 1'b1;
          if (rx_count + RW'(1) == rx_len_l) state_nxt = ST_IDLE;
        end else if (expired) begin
          state_nxt = ST_IDLE;
          end_code  = ERR_TIMEOUT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && state_nxt == ST_IDLE) done = 1'b1;
    // abort overrides whatever this cycle would otherwise have done
    if (abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      tx_push   = 1'b0;
      capture   = 1'b0;
      end_code  = ERR_ABORTED;
      done      = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Descriptor capture at start; lengths clamped to the supported maxima
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_synch_l <= 1'b0;
      opcode_l     <= '0;
      data_l       <= '0;
      data_len_l   <= '0;
      wait_ack_l   <= '0;
      rx_len_l     <= '0;
    end else if (latch) begin
      send_synch_l <= send_synch;
      opcode_l     <= opcode;
      data_l       <= data;
      data_len_l   <= (data_len > DATA_MAX) ? DATA_MAX : data_len;
      wait_ack_l   <= wait_ack_after;
      rx_len_l     <= (rx_len > RX_MAX) ? RX_MAX : rx_len;
    end
  end

  // Datapath: data index, response capture, result code and registered TX write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done     <= 1'b0;
      data_idx      <= '0;
      rx_count      <= '0;
      rx_data       <= '0;
      error_code    <= ERR_NONE;
      tx_fifo_wr_en <= 1'b0;
      tx_fifo_data  <= '0;
    end else begin
      init_done     <= 1'b1;
      tx_fifo_wr_en <= tx_push;
      if (tx_push) tx_fifo_data <= tx_byte;
      if (latch) begin
        data_idx   <= '0;
        rx_count   <= '0;
        error_code <= ERR_NONE;
      end else begin
        data_idx <= idx_nxt;
        if (capture) begin
          rx_data[rx_count[RI-1:0]] <= rx_fifo_data;
          rx_count                  <= rx_count + RW'(1);
        end
        if (done) error_code <= end_code;
      end
    end
  end

  // send_synch_l is consumed only through the IDLE transition choice; keep it observable
  logic unused_ok;
  assign unused_ok = send_synch_l;

endmodule
